// File: rtl/max7219_pkg.sv
// Shared constants and helpers for the MAX7219 cascade driver: register map,
// power-up register sequence and hex-to-segment decoding.
package max7219_pkg;

  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  localparam logic [2:0] INIT_LAST      = 3'd5;
  localparam logic [2:0] INIT_IDX_INTEN = 3'd4;

  // Init sequence entry {addr, data}; shut down first so reconfiguration is not visible.
  function automatic logic [11:0] init_entry(input logic [2:0] idx, input logic [3:0] inten);
    logic [11:0] e;
    case (idx)
      3'd0:    e = {REG_SHUTDOWN, 8'h00};
      3'd1:    e = {REG_TEST, 8'h00};
      3'd2:    e = {REG_SCANLIMIT, 8'h07};
      3'd3:    e = {REG_DECODE, 8'h00};
      3'd4:    e = {REG_INTENSITY, 4'h0, inten};
      default: e = {REG_SHUTDOWN, 8'h01};
    endcase
    return e;
  endfunction

  // Segment pattern, bit6..0 = A..G.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
    endcase
    return s;
  endfunction

  // True when nibbles k..7 of v are all zero.
  function automatic logic upper_zero(input logic [31:0] v, input logic [2:0] k);
    return (v >> {k, 2'b00}) == 32'd0;
  endfunction

endpackage

// File: rtl/max7219_shift.sv
// Serialises one NUM_DEV-word register write onto din/clk/load, MSB first,
// with a one-cycle load setup and a LOAD_HOLD-cycle latch phase.
module max7219_shift #(
  parameter int NUM_DEV   = 1,
  parameter int CLK_DIV   = 10,
  parameter int LOAD_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [16*NUM_DEV-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic                  max_din,
  output logic                  max_clk,
  output logic                  max_load
);

  localparam int W    = 16 * NUM_DEV;
  localparam int HALF = CLK_DIV / 2;
  localparam int BW   = $clog2(W);
  localparam int DW   = $clog2(CLK_DIV);
  localparam int HW   = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_SHIFT = 2'd2;
  localparam logic [1:0] PH_HOLD  = 2'd3;

  logic [1:0]    phase_reg;
  logic [W-1:0]  sr_reg;
  logic [BW-1:0] bit_reg;
  logic [DW-1:0] div_reg;
  logic [HW-1:0] hold_reg;
  logic          din_reg;
  logic          sclk_reg;
  logic          load_reg;
  logic          done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= PH_IDLE;
      sr_reg    <= '0;
      bit_reg   <= '0;
      div_reg   <= '0;
      hold_reg  <= '0;
      din_reg   <= 1'b0;
      sclk_reg  <= 1'b0;
      load_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (phase_reg)
        PH_IDLE: begin
          if (start) begin
            phase_reg <= PH_SETUP;
            sr_reg    <= data;
            load_reg  <= 1'b0;
          end
        end
        PH_SETUP: begin
          phase_reg <= PH_SHIFT;
          din_reg   <= sr_reg[W-1];
          sr_reg    <= {sr_reg[W-2:0], 1'b0};
          bit_reg   <= '0;
          div_reg   <= '0;
          sclk_reg  <= 1'b0;
        end
        PH_SHIFT: begin
          if (div_reg == DW'(CLK_DIV - 1)) begin
            div_reg  <= '0;
            sclk_reg <= 1'b0;
            if (bit_reg == BW'(W - 1)) begin
              phase_reg <= PH_HOLD;
              load_reg  <= 1'b1;
              hold_reg  <= '0;
            end else begin
              // New bit is presented on the same cycle the clock falls.
              bit_reg <= bit_reg + 1'b1;
              din_reg <= sr_reg[W-1];
              sr_reg  <= {sr_reg[W-2:0], 1'b0};
            end
          end else begin
            div_reg <= div_reg + 1'b1;
            if (div_reg == DW'(HALF - 1)) sclk_reg <= 1'b1;
          end
        end
        default: begin
          if (hold_reg == HW'(LOAD_HOLD - 1)) begin
            phase_reg <= PH_IDLE;
            done_reg  <= 1'b1;
            din_reg   <= 1'b0;
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy     = (phase_reg != PH_IDLE);
  assign done     = done_reg;
  assign max_din  = din_reg;
  assign max_clk  = sclk_reg;
  assign max_load = load_reg;

endmodule

// File: rtl/max7219_chain.sv
// Continuously refreshes a cascade of MAX7219 8-digit modules from a packed hex
// vector: power-up wait, init sequence, then snapshot-consistent frames.
module max7219_chain
  import max7219_pkg::*;
#(
  parameter int NUM_DEV       = 1,
  parameter int CLK_DIV       = 10,
  parameter int POR_CYCLES    = 1048576,
  parameter int REINIT_CYCLES = 33554432,
  parameter int LOAD_HOLD     = 4,
  parameter int BLANK_LZ      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [32*NUM_DEV-1:0] display_value,
  input  logic [8*NUM_DEV-1:0]  dp,
  input  logic [3:0]            intensity,
  output logic                  max_din,
  output logic                  max_clk,
  output logic                  max_load,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int W = 16 * NUM_DEV;

  localparam logic [2:0] ST_POR   = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_SNAP  = 3'd2;
  localparam logic [2:0] ST_INTEN = 3'd3;
  localparam logic [2:0] ST_DIGIT = 3'd4;

  logic [2:0]            state_reg;
  logic [31:0]           por_cnt_reg;
  logic [31:0]           re_cnt_reg;
  logic                  reinit_pend_reg;
  logic [2:0]            init_idx_reg;
  logic [2:0]            digit_reg;
  logic                  wait_reg;
  logic                  start_reg;
  logic [W-1:0]          word_reg;
  logic [32*NUM_DEV-1:0] snap_val_reg;
  logic [8*NUM_DEV-1:0]  snap_dp_reg;
  logic [3:0]            snap_int_reg;
  logic [3:0]            last_int_reg;
  logic                  frame_done_reg;

  logic         sh_busy;
  logic         sh_done;
  logic         can_start;
  logic         frame_end;
  logic [3:0]   digit_addr;
  logic [W-1:0] init_all;
  logic [W-1:0] inten_all;
  logic [W-1:0] digit_all;

  assign digit_addr = {1'b0, digit_reg} + 4'd1;
  assign can_start  = !wait_reg && !sh_busy && !start_reg;
  assign frame_end  = (state_reg == ST_DIGIT) && wait_reg && sh_done && (digit_reg == 3'd7);

  // Device gi occupies word slot gi, so the farthest device is shifted out first.
  for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dev
    logic [31:0] dev_val;
    logic [7:0]  dev_dp;
    logic        blank;
    assign dev_val = snap_val_reg[32*gi +: 32];
    assign dev_dp  = snap_dp_reg[8*gi +: 8];
    assign blank   = (BLANK_LZ != 0) && (digit_reg != 3'd0) && upper_zero(dev_val, digit_reg);
    assign digit_all[16*gi +: 16] = {4'h0, digit_addr, dev_dp[digit_reg],
                                     blank ? 7'h00 : seg7(dev_val[4*digit_reg +: 4])};
    assign init_all[16*gi +: 16]  = {4'h0, init_entry(init_idx_reg, intensity)};
    assign inten_all[16*gi +: 16] = {4'h0, REG_INTENSITY, 4'h0, snap_int_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_POR;
      por_cnt_reg     <= '0;
      re_cnt_reg      <= '0;
      reinit_pend_reg <= 1'b0;
      init_idx_reg    <= '0;
      digit_reg       <= '0;
      wait_reg        <= 1'b0;
      start_reg       <= 1'b0;
      word_reg        <= '0;
      snap_val_reg    <= '0;
      snap_dp_reg     <= '0;
      snap_int_reg    <= '0;
      last_int_reg    <= '0;
      frame_done_reg  <= 1'b0;
    end else begin
      start_reg      <= 1'b0;
      frame_done_reg <= 1'b0;

      // Pending re-init is only honoured at a frame boundary.
      if (REINIT_CYCLES != 0 && state_reg != ST_POR) begin
        if (re_cnt_reg == 32'(REINIT_CYCLES - 1)) begin
          re_cnt_reg      <= '0;
          reinit_pend_reg <= 1'b1;
        end else begin
          re_cnt_reg <= re_cnt_reg + 1'b1;
          if (frame_end && reinit_pend_reg) reinit_pend_reg <= 1'b0;
        end
      end

      case (state_reg)
        ST_POR: begin
          if (por_cnt_reg == 32'(POR_CYCLES - 1)) begin
            state_reg    <= ST_INIT;
            init_idx_reg <= '0;
          end else begin
            por_cnt_reg <= por_cnt_reg + 1'b1;
          end
        end
        ST_INIT: begin
          if (can_start) begin
            start_reg <= 1'b1;
            wait_reg  <= 1'b1;
            word_reg  <= init_all;
            if (init_idx_reg == INIT_IDX_INTEN) last_int_reg <= intensity;
          end else if (wait_reg && sh_done) begin
            wait_reg <= 1'b0;
            if (init_idx_reg == INIT_LAST) state_reg <= ST_SNAP;
            else init_idx_reg <= init_idx_reg + 1'b1;
          end
        end
        ST_SNAP: begin
          snap_val_reg <= display_value;
          snap_dp_reg  <= dp;
          snap_int_reg <= intensity;
          digit_reg    <= '0;
          state_reg    <= (intensity != last_int_reg) ? ST_INTEN : ST_DIGIT;
        end
        ST_INTEN: begin
          if (can_start) begin
            start_reg    <= 1'b1;
            wait_reg     <= 1'b1;
            word_reg     <= inten_all;
            last_int_reg <= snap_int_reg;
          end else if (wait_reg && sh_done) begin
            wait_reg  <= 1'b0;
            state_reg <= ST_DIGIT;
          end
        end
        default: begin
          if (can_start) begin
            start_reg <= 1'b1;
            wait_reg  <= 1'b1;
            word_reg  <= digit_all;
          end else if (wait_reg && sh_done) begin
            wait_reg <= 1'b0;
            if (digit_reg == 3'd7) begin
              frame_done_reg <= 1'b1;
              if (reinit_pend_reg) begin
                state_reg    <= ST_INIT;
                init_idx_reg <= '0;
              end else begin
                state_reg <= ST_SNAP;
              end
            end else begin
              digit_reg <= digit_reg + 1'b1;
            end
          end
        end
      endcase
    end
  end

  max7219_shift #(
    .NUM_DEV   (NUM_DEV),
    .CLK_DIV   (CLK_DIV),
    .LOAD_HOLD (LOAD_HOLD)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_reg),
    .data     (word_reg),
    .busy     (sh_busy),
    .done     (sh_done),
    .max_din  (max_din),
    .max_clk  (max_clk),
    .max_load (max_load)
  );

  assign busy       = (state_reg != ST_POR);
  assign frame_done = frame_done_reg;

endmodule
